rem_alert_ctrl: RTL and testbench
=================================

// Module: rem_alert_ctrl
// PURPOSE
//  Downstream of the reminder timer: consumes its 1-cycle notif pulse and runs the user alert.
//  Drives a beeping buzzer and an alert LED until the user acks, snoozes or the ring times out.
//  Snooze re-arms the ring after a fixed delay, up to a limit.
//  Reports dismissed, missed and dropped events as 1-cycle pulses for a status/log stage.
// PARAMETERS
//  BEEP_ON    2   cycles buzz=1 per beep period (>=1)
//  BEEP_OFF   2   cycles buzz=0 per beep period (>=1)
//  RING_MAX   16  cycles spent in RING before auto-timeout (>=1)
//  SNOOZE_CYC 8   cycles spent in SNOOZED before re-ring (>=1)
//  MAX_SNOOZE 2   snoozes honoured per alert (0..15)
//  CW         16  width of internal cycle counters; all count params < 2**CW
// PORTS
//  clk       in   1  clock, all logic on rising edge
//  rst       in   1  asynchronous, active-high reset
//  notif     in   1  alert request pulse from reminder timer
//  ack       in   1  user dismiss, level-sampled each cycle
//  snooze    in   1  user snooze, level-sampled each cycle
//  buzz      out  1  buzzer drive, registered
//  led       out  1  alert LED: 1 in RING and SNOOZED, registered
//  dismissed out  1  1-cycle pulse: alert acked
//  missed    out  1  1-cycle pulse: ring timed out without ack
//  dropped   out  1  1-cycle pulse: notif arrived while not IDLE
//  snz_cnt   out  4  snoozes used in the current alert
// BEHAVIOUR
//  Reset: state=IDLE; buzz, led, dismissed, missed, dropped = 0; snz_cnt = 0; counters = 0.
//  Reset is honoured in any state, mid-ring or mid-snooze; no pulse is generated on reset.
//  All outputs are registered. Pulses are high for exactly one cycle, then cleared.
//  IDLE: buzz=0, led=0. Edge with notif=1 -> RING; buzz<=1, led<=1, snz_cnt<=0, ring_cnt<=0, beep_cnt<=0.
//  RING: ring_cnt increments each cycle.
//   Beep: buzz=1 for BEEP_ON cycles, then 0 for BEEP_OFF cycles, repeating.
//   Beep pattern restarts in the on-phase on every entry to RING.
//   Priority per edge: ack > snooze > timeout.
//   ack: -> IDLE; buzz<=0, led<=0, dismissed<=1.
//   snooze and snz_cnt<MAX_SNOOZE: -> SNOOZED; snz_cnt+=1, wait_cnt<=0, buzz<=0.
//   snooze and snz_cnt==MAX_SNOOZE: ignored; RING continues unchanged.
//   timeout, on the edge where ring_cnt==RING_MAX-1: -> IDLE; buzz<=0, led<=0, missed<=1.
//   Result: RING lasts exactly RING_MAX cycles.
//  SNOOZED: buzz=0, led=1; wait_cnt increments each cycle.
//   ack: -> IDLE, dismissed<=1.
//   snooze: ignored.
//   On the edge where wait_cnt==SNOOZE_CYC-1: -> RING; ring_cnt<=0, beep restarts, buzz<=1.
//  notif in RING or SNOOZED: dropped<=1 for one cycle; state and counters unaffected.
//  notif in IDLE on the same edge as any other input: only notif matters; ack and snooze are ignored in IDLE.
//  snz_cnt holds its value after returning to IDLE; it clears on the next accepted notif.
//  Counters never wrap: each is reset on state entry and bounded by its parameter.
//  Unused state encodings -> IDLE with all outputs 0.
// TESTING (defaults)
//  1. notif pulse, no user input -> buzz pattern 1,1,0,0 repeated for 16 cycles with led=1.
//     Then buzz=0, led=0, missed=1 for 1 cycle, snz_cnt=0.
//  2. notif, then ack in the 5th RING cycle -> next cycle buzz=0, led=0, dismissed=1 for 1 cycle, missed never asserted.
//  3. notif, then snooze in the 3rd RING cycle -> 8 cycles with buzz=0, led=1, snz_cnt=1.
//     Then RING re-entered with buzz=1,1,0,0 from the start.
//  4. Snooze twice, then snooze a 3rd time -> third ignored: snz_cnt stays 2, buzz keeps beeping.
//     missed pulses after 16 cycles of that ring.
//  5. ack and snooze in the same RING cycle -> dismissed=1, no SNOOZED entry.
//     notif mid-RING -> dropped=1 for 1 cycle and timeout cycle unchanged.
//  6. rst asserted mid-SNOOZED -> all outputs 0 immediately.
//     After release, a notif starts a fresh RING with snz_cnt=0.

Source files
------------

// File: rtl/rem_alert_ctrl.sv
// Alert sequencer for the reminder timer's notif pulse. It drives a beeping buzzer and the alert LED,
// handles ack and snooze from the user, and reports dismissed, missed and dropped events as 1-cycle pulses.
//
// state   | meaning
// IDLE    | no alert active, waiting for notif
// RING    | buzzer beeping, LED on, waiting for ack/snooze/timeout
// SNOOZED | buzzer silent, LED on, waiting out the snooze delay
module rem_alert_ctrl #(
  parameter int BEEP_ON    = 2,
  parameter int BEEP_OFF   = 2,
  parameter int RING_MAX   = 16,
  parameter int SNOOZE_CYC = 8,
  parameter int MAX_SNOOZE = 2,
  parameter int CW         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       notif,
  input  logic       ack,
  input  logic       snooze,
  output logic       buzz,
  output logic       led,
  output logic       dismissed,
  output logic       missed,
  output logic       dropped,
  output logic [3:0] snz_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RING    = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  localparam logic [CW-1:0] BEEP_ON_C   = CW'(BEEP_ON);
  localparam logic [CW-1:0] BEEP_LAST   = CW'(BEEP_ON + BEEP_OFF - 1);
  localparam logic [CW-1:0] RING_LAST   = CW'(RING_MAX - 1);
  localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_CYC - 1);
  localparam logic [3:0]    MAX_SNZ     = 4'(MAX_SNOOZE);

  state_t        state, state_nx;
  logic [CW-1:0] ring_cnt, ring_nx;
  logic [CW-1:0] wait_cnt, wait_nx;
  logic [CW-1:0] beep_cnt, beep_nx, beep_inc;
  logic [3:0]    snz_nx;
  logic          buzz_nx, led_nx, dis_nx, miss_nx, drop_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ring_cnt  <= '0;
      wait_cnt  <= '0;
      beep_cnt  <= '0;
      snz_cnt   <= '0;
      buzz      <= 1'b0;
      led       <= 1'b0;
      dismissed <= 1'b0;
      missed    <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_nx;
      ring_cnt  <= ring_nx;
      wait_cnt  <= wait_nx;
      beep_cnt  <= beep_nx;
      snz_cnt   <= snz_nx;
      buzz      <= buzz_nx;
      led       <= led_nx;
      dismissed <= dis_nx;
      missed    <= miss_nx;
      dropped   <= drop_nx;
    end
  end

  // Beep phase wraps over one on+off period; buzz follows the phase the next cycle will be in.
  assign beep_inc = (beep_cnt == BEEP_LAST) ? '0 : beep_cnt + 1'b1;

  always_comb begin
    state_nx = state;
    ring_nx  = ring_cnt;
    wait_nx  = wait_cnt;
    beep_nx  = beep_cnt;
    snz_nx   = snz_cnt;
    buzz_nx  = 1'b0;
    led_nx   = 1'b0;
    dis_nx   = 1'b0;
    miss_nx  = 1'b0;
    drop_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (notif) begin
          state_nx = RING;
          ring_nx  = '0;
          beep_nx  = '0;
          snz_nx   = '0;
          buzz_nx  = 1'b1;
          led_nx   = 1'b1;
        end
      end
      RING: begin
        drop_nx = notif;
        led_nx  = 1'b1;
        if (ack) begin
          state_nx = IDLE;
          led_nx   = 1'b0;
          dis_nx   = 1'b1;
        end else if (snooze && (snz_cnt < MAX_SNZ)) begin
          state_nx = SNOOZED;
          snz_nx   = snz_cnt + 4'd1;
          wait_nx  = '0;
        end else if (ring_cnt == RING_LAST) begin
          state_nx = IDLE;
          led_nx   = 1'b0;
          miss_nx  = 1'b1;
        end else begin
          ring_nx = ring_cnt + 1'b1;
          beep_nx = beep_inc;
          buzz_nx = (beep_inc < BEEP_ON_C);
        end
      end
      SNOOZED: begin
        drop_nx = notif;
        led_nx  = 1'b1;
        if (ack) begin
          state_nx = IDLE;
          led_nx   = 1'b0;
          dis_nx   = 1'b1;
        end else if (wait_cnt == SNOOZE_LAST) begin
          state_nx = RING;
          ring_nx  = '0;
          beep_nx  = '0;
          buzz_nx  = 1'b1;
        end else begin
          wait_nx = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        ring_nx  = '0;
        wait_nx  = '0;
        beep_nx  = '0;
        snz_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rem_alert_ctrl.sv
// Scoreboard bench for rem_alert_ctrl: a phase-time reference model predicts each cycle's outputs,
// a monitor pops and compares them after every rising edge.
module tb_rem_alert_ctrl;

  localparam int BEEP_ON    = 2;
  localparam int BEEP_OFF   = 2;
  localparam int RING_MAX   = 16;
  localparam int SNOOZE_CYC = 8;
  localparam int MAX_SNOOZE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       notif = 1'b0, ack = 1'b0, snooze = 1'b0;
  logic       buzz, led, dismissed, missed, dropped;
  logic [3:0] snz_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] expq[$];

  // Model state: mode 0=idle 1=ringing 2=snoozed, t = cycles already spent in the current phase.
  int m_mode = 0;
  int m_t    = 0;
  int m_snz  = 0;

  rem_alert_ctrl #(
    .BEEP_ON(BEEP_ON), .BEEP_OFF(BEEP_OFF), .RING_MAX(RING_MAX),
    .SNOOZE_CYC(SNOOZE_CYC), .MAX_SNOOZE(MAX_SNOOZE), .CW(16)
  ) dut (
    .clk(clk), .rst(rst), .notif(notif), .ack(ack), .snooze(snooze),
    .buzz(buzz), .led(led), .dismissed(dismissed), .missed(missed),
    .dropped(dropped), .snz_cnt(snz_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] actual();
    return {buzz, led, dismissed, missed, dropped, snz_cnt};
  endfunction

  task automatic model_step(input logic n, input logic a, input logic s, output logic [8:0] e);
    logic dis, mis, drp, bz;
    dis = 1'b0; mis = 1'b0;
    drp = n && (m_mode != 0);
    if (m_mode == 0) begin
      if (n) begin m_mode = 1; m_t = 0; m_snz = 0; end
    end else if (a) begin
      m_mode = 0; dis = 1'b1;
    end else if (m_mode == 1) begin
      if (s && m_snz < MAX_SNOOZE) begin m_mode = 2; m_t = 0; m_snz++; end
      else if (m_t == RING_MAX - 1) begin m_mode = 0; mis = 1'b1; end
      else m_t++;
    end else begin
      if (m_t == SNOOZE_CYC - 1) begin m_mode = 1; m_t = 0; end
      else m_t++;
    end
    bz = (m_mode == 1) && ((m_t % (BEEP_ON + BEEP_OFF)) < BEEP_ON);
    e = {bz, m_mode != 0, dis, mis, drp, 4'(m_snz)};
  endtask

  task automatic cycle(input logic n, input logic a, input logic s);
    logic [8:0] e;
    @(negedge clk);
    notif = n; ack = a; snooze = s;
    model_step(n, a, s, e);
    expq.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset away from the clock edge and checks the outputs clear without waiting for one.
  task automatic do_reset();
    @(negedge clk);
    notif = 1'b0; ack = 1'b0; snooze = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (actual() !== 9'd0) begin
      errors++;
      $display("FAIL async_reset act=%b exp=%b", actual(), 9'd0);
    end
    expq.delete();
    m_mode = 0; m_t = 0; m_snz = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst && expq.size() > 0) begin
      logic [8:0] e;
      e = expq.pop_front();
      checks++;
      if (actual() !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d act{buzz,led,dis,miss,drop,snz}=%b exp=%b", cyc, actual(), e);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (actual() !== 9'd0) begin
      errors++;
      $display("FAIL reset_state act=%b exp=%b", actual(), 9'd0);
    end

    // Unattended ring times out.
    cycle(1, 0, 0); idle(20);
    // Ack in the 5th ring cycle.
    cycle(1, 0, 0); idle(4); cycle(0, 1, 0); idle(4);
    // Snooze in the 3rd ring cycle, re-ring, then ack.
    cycle(1, 0, 0); idle(2); cycle(0, 0, 1); idle(12); cycle(0, 1, 0); idle(2);
    // Snooze limit reached, third snooze ignored, then timeout.
    cycle(1, 0, 0); cycle(0, 0, 1); idle(9); cycle(0, 0, 1); idle(9);
    cycle(0, 0, 1); idle(20);
    // Ack and snooze together; notif while ringing and while snoozed.
    cycle(1, 0, 0); cycle(0, 1, 1); idle(2);
    cycle(1, 0, 0); idle(5); cycle(1, 0, 0); idle(3); cycle(0, 0, 1);
    cycle(1, 0, 0); cycle(0, 1, 1); idle(30);
    // Notif together with ack/snooze while idle.
    cycle(1, 1, 1); idle(18);
    // Reset mid-snooze, then a fresh alert.
    cycle(1, 0, 0); cycle(0, 0, 1); idle(3);
    do_reset();
    cycle(1, 0, 0); idle(20);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle($urandom_range(0, 11) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0);
    end

    idle(1);
    @(posedge clk); #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain act=%0d exp=0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
